usb_pulpino_mailbox: RTL
========================

# usb_pulpino_mailbox

Parametrised, bidirectional, buffered mailbox between the USB register block and the PULPino GPIO port, generalising the single-register flicker channel to two independent FIFOs with per-word toggle handshakes. USB pushes words into a USB→PULPino FIFO and pops from a PULPino→USB FIFO; PULPino does the converse. Sits in `cw305_top` between `cw305_reg_pulpino` and the PULPino `gpio_in`/`gpio_out` buses, entirely in the `pulpino_clk` domain. CDC into that domain is done upstream.

## Interface
- `pDATA_WIDTH`, 8: word width, both directions.
- `pDEPTH`, 16: entries per FIFO; power of two, ≥2.
- `pCNT_WIDTH`, `$clog2(pDEPTH+1)`: derived localparam, fill-count width.
---
- `clk` in 1: PULPino clock; sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `usb_wr_data` in pDATA_WIDTH: word to push into U2P FIFO.
- `usb_wr_toggle` in 1: each level change = one U2P push.
- `usb_wr_ack` out 1: toggles once per accepted U2P push.
- `usb_rd_data` out pDATA_WIDTH: P2U head word; 0 when empty.
- `usb_rd_valid` out 1: P2U FIFO non-empty.
- `usb_rd_toggle` in 1: each level change = one P2U pop.
- `pulpino_wr_data` in pDATA_WIDTH: word to push into P2U FIFO.
- `pulpino_wr_toggle` in 1: each level change = one P2U push.
- `pulpino_wr_ack` out 1: toggles once per accepted P2U push.
- `pulpino_rd_data` out pDATA_WIDTH: U2P head word; 0 when empty.
- `pulpino_rd_valid` out 1: U2P FIFO non-empty.
- `pulpino_rd_toggle` in 1: each level change = one U2P pop.
- `u2p_count` out pCNT_WIDTH: U2P fill level, 0..pDEPTH.
- `p2u_count` out pCNT_WIDTH: P2U fill level, 0..pDEPTH.
- `status_clr` in 1: single-cycle pulse; clears sticky flags.
- `status` out 4: sticky {p2u_underflow, p2u_overflow, u2p_underflow, u2p_overflow}.

## Operation
- Event detection: one registered copy per toggle input; event = input XOR copy; copy updated every cycle. Copies reset to 0. All toggle inputs must be low while `rst_n` is asserted; producers are reset by the same reset.
- Push event, FIFO not full: write data at `wr_ptr`, increment `wr_ptr` and count, toggle the side's ack.
- Push event, FIFO full and no same-cycle pop: word dropped, ack not toggled, overflow flag set.
- Pop event, FIFO non-empty: increment `rd_ptr`, decrement count.
- Pop event, FIFO empty: no state change, underflow flag set.
- Simultaneous push and pop, non-empty: both performed; count unchanged. If the FIFO is full, the push is accepted and no overflow is flagged.
- Simultaneous push and pop, empty: push performed, pop flagged as underflow. There is no bypass.
- Pointers are log2(pDEPTH) bits and wrap naturally at pDEPTH.
- `rd_data` = mem[rd_ptr] when valid, else 0. `valid` = (count ≠ 0).
- Sticky flags: set on event and held until `status_clr`. A set event in the same cycle as `status_clr` wins, so the flag stays 1.
- The two FIFOs are fully independent; all four events may occur in one cycle.

## Timing
- Reset values: counts 0, valid 0, rd_data 0, acks 0, status 0, pointers 0, toggle copies 0.
- A toggle change sampled at edge N acts at edge N+1, because the copy is registered at N. Count, valid, rd_data and ack update after edge N+1. Input-to-output latency is 2 cycles.
- Producer must hold `*_wr_data` stable from its toggle change until the corresponding ack toggle, or for 2 cycles if the FIFO is full.
- Minimum toggle spacing is 1 cycle. Back-to-back toggles give one event per cycle.
- Asserting reset mid-operation discards FIFO contents immediately and asynchronously. Memory contents are not cleared but are unobservable because rd_data is gated.

## Structure
- Package `usb_pulpino_mailbox_pkg`: status bit index constants (STAT_U2P_OVF=0, STAT_U2P_UDF=1, STAT_P2U_OVF=2, STAT_P2U_UDF=3).
- Sub-module `mailbox_fifo` (pDATA_WIDTH, pDEPTH): push/pop strobes in; head data, valid, count, overflow and underflow pulses out. Instanced twice, as U2P and P2U.
- The top handles toggle edge detection, ack generation and sticky flags.

## Test plan
- Reset, then USB pushes 0xA5 → 2 cycles later `pulpino_rd_valid`=1, `pulpino_rd_data`=0xA5, `u2p_count`=1, `usb_wr_ack`=1.
- Pulpino pushes 16 words 0x00..0x0F, then a 17th word 0xFF → `p2u_count`=16, `status[2]`=1, ack toggled exactly 16 times; USB pops 16 times and reads 0x00..0x0F in order.
- Fill U2P to 16, then push and pop in the same cycle → count stays 16, no overflow, the new word is read last.
- Pop an empty P2U → `status[3]`=1, count 0; pulse `status_clr` → `status`=0; clear coinciding with a new underflow → bit stays 1.
- Perform 40 push/pop pairs through U2P → pointer wraps, data sequence intact, count ends at 0.
- Assert `rst_n`=0 with 5 words queued → within the same cycle counts=0, valid=0, rd_data=0; after release a new push yields a single correct word.

Source files
------------

// File: rtl/usb_pulpino_mailbox_pkg.sv
// rtl/usb_pulpino_mailbox_pkg.sv - shared constants for the USB/PULPino mailbox
package usb_pulpino_mailbox_pkg;

    localparam int STAT_WIDTH   = 4;
    localparam int STAT_U2P_OVF = 0;
    localparam int STAT_U2P_UDF = 1;
    localparam int STAT_P2U_OVF = 2;
    localparam int STAT_P2U_UDF = 3;

endpackage

// File: rtl/usb_pulpino_mailbox_fifo.sv
// rtl/usb_pulpino_mailbox_fifo.sv - single-clock FIFO with strobe push/pop and error pulses
module mailbox_fifo #(
    parameter  int pDATA_WIDTH = 8,
    parameter  int pDEPTH      = 16,
    localparam int pCNT_WIDTH  = $clog2(pDEPTH + 1),
    localparam int pPTR_WIDTH  = $clog2(pDEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [pDATA_WIDTH-1:0] push_data_i,
    input  logic                   pop_i,
    output logic [pDATA_WIDTH-1:0] rd_data_o,
    output logic                   valid_o,
    output logic [pCNT_WIDTH-1:0]  count_o,
    output logic                   push_ok_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam logic [pCNT_WIDTH-1:0] CNT_FULL = pCNT_WIDTH'(pDEPTH);
    localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(1);
    localparam logic [pPTR_WIDTH-1:0] PTR_ONE  = pPTR_WIDTH'(1);

    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    logic [pPTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [pPTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [pCNT_WIDTH-1:0]  count_q, count_d;
    logic                   full, empty, pop_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop on a full FIFO frees the slot the same-cycle push lands in,
    // so a full FIFO still accepts a push that coincides with a pop.
    assign pop_ok      = pop_i & ~empty;
    assign push_ok_o   = push_i & (~full | pop_i);
    assign overflow_o  = push_i & full & ~pop_i;
    assign underflow_o = pop_i & empty;

    assign valid_o   = ~empty;
    assign count_o   = count_q;
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

    // Next-state for pointers and fill count; pointers wrap at pDEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_o) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)    rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok_o, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; left uninitialised since rd_data is gated by valid.
    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/usb_pulpino_mailbox.sv
// rtl/usb_pulpino_mailbox.sv - bidirectional toggle-handshake mailbox between USB regs and PULPino GPIO
module usb_pulpino_mailbox
    import usb_pulpino_mailbox_pkg::*;
#(
    parameter  int pDATA_WIDTH = 8,
    parameter  int pDEPTH      = 16,
    localparam int pCNT_WIDTH  = $clog2(pDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [pDATA_WIDTH-1:0] usb_wr_data,
    input  logic                   usb_wr_toggle,
    output logic                   usb_wr_ack,
    output logic [pDATA_WIDTH-1:0] usb_rd_data,
    output logic                   usb_rd_valid,
    input  logic                   usb_rd_toggle,
    input  logic [pDATA_WIDTH-1:0] pulpino_wr_data,
    input  logic                   pulpino_wr_toggle,
    output logic                   pulpino_wr_ack,
    output logic [pDATA_WIDTH-1:0] pulpino_rd_data,
    output logic                   pulpino_rd_valid,
    input  logic                   pulpino_rd_toggle,
    output logic [pCNT_WIDTH-1:0]  u2p_count,
    output logic [pCNT_WIDTH-1:0]  p2u_count,
    input  logic                   status_clr,
    output logic [3:0]             status
);

    // Toggle lanes: 0 usb_wr, 1 usb_rd, 2 pulpino_wr, 3 pulpino_rd
    logic [3:0] tog;
    logic [3:0] copy_q;
    logic [3:0] ev_q;

    logic u2p_push_ok, u2p_ovf, u2p_udf;
    logic p2u_push_ok, p2u_ovf, p2u_udf;

    logic usb_ack_q, pul_ack_q;
    logic [STAT_WIDTH-1:0] status_q, status_set;

    assign tog = {pulpino_rd_toggle, pulpino_wr_toggle, usb_rd_toggle, usb_wr_toggle};

    // Edge detection; the event itself is registered, giving a two-cycle input-to-output latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_q <= '0;
            ev_q   <= '0;
        end else begin
            copy_q <= tog;
            ev_q   <= tog ^ copy_q;
        end
    end

    mailbox_fifo #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pDEPTH      (pDEPTH)
    ) u_u2p (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ev_q[0]),
        .push_data_i (usb_wr_data),
        .pop_i       (ev_q[3]),
        .rd_data_o   (pulpino_rd_data),
        .valid_o     (pulpino_rd_valid),
        .count_o     (u2p_count),
        .push_ok_o   (u2p_push_ok),
        .overflow_o  (u2p_ovf),
        .underflow_o (u2p_udf)
    );

    mailbox_fifo #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pDEPTH      (pDEPTH)
    ) u_p2u (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ev_q[2]),
        .push_data_i (pulpino_wr_data),
        .pop_i       (ev_q[1]),
        .rd_data_o   (usb_rd_data),
        .valid_o     (usb_rd_valid),
        .count_o     (p2u_count),
        .push_ok_o   (p2u_push_ok),
        .overflow_o  (p2u_ovf),
        .underflow_o (p2u_udf)
    );

    // Gather the per-cycle error pulses into status bit positions.
    always_comb begin
        status_set               = '0;
        status_set[STAT_U2P_OVF] = u2p_ovf;
        status_set[STAT_U2P_UDF] = u2p_udf;
        status_set[STAT_P2U_OVF] = p2u_ovf;
        status_set[STAT_P2U_UDF] = p2u_udf;
    end

    // Acks flip once per accepted push; sticky flags let a new event win over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usb_ack_q <= 1'b0;
            pul_ack_q <= 1'b0;
            status_q  <= '0;
        end else begin
            usb_ack_q <= usb_ack_q ^ u2p_push_ok;
            pul_ack_q <= pul_ack_q ^ p2u_push_ok;
            status_q  <= (status_q & ~{STAT_WIDTH{status_clr}}) | status_set;
        end
    end

    assign usb_wr_ack     = usb_ack_q;
    assign pulpino_wr_ack = pul_ack_q;
    assign status         = status_q;

endmodule
